// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S stereo receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StRun
  } i2s_state_e;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefSlotWidth  = 32;
  localparam int unsigned DefSckDiv     = 8;
  localparam int unsigned DefSkipFrames = 1;
  localparam int unsigned DefDcShift    = 10;

  // Clamp a signed value into the range of a width-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned     width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/i2s_stereo_rx_if.sv
// Sample-pair handshake between the I2S receiver and its consumer.
interface i2s_stereo_rx_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] left_data_out;
  logic signed [DATA_WIDTH-1:0] right_data_out;
  logic                         sample_valid;
  logic                         sample_ready;

  modport master (
    output left_data_out,
    output right_data_out,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_data_out,
    input  right_data_out,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_dc_block.sv
// Per-channel DC removal: subtracts a leaky running average and saturates the result.
module i2s_dc_block
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DC_SHIFT   = DefDcShift
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic                         update,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam int unsigned AccWidth = DATA_WIDTH + DC_SHIFT;

  logic signed [AccWidth-1:0] acc_q;
  logic signed [AccWidth-1:0] avg;
  logic signed [AccWidth:0]   diff;

  assign avg  = acc_q >>> DC_SHIFT;
  assign diff = $signed({{(AccWidth + 1 - DATA_WIDTH){x[DATA_WIDTH-1]}}, x})
              - $signed({avg[AccWidth-1], avg});
  assign y    = DATA_WIDTH'(sat_signed(32'(diff), DATA_WIDTH));

  // The accumulator integrates the unsaturated difference so the average tracks the true input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (update) begin
      acc_q <= acc_q + $signed(diff[AccWidth-1:0]);
    end
  end

endmodule

// File: rtl/i2s_stereo_rx.sv
// Master-mode I2S stereo receiver: generates sck/ws, deserialises both slots, hands out pairs.
// Defining I2S_RX_DC_BLOCK_EN adds per-channel DC removal behind one extra register stage.
module i2s_stereo_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned SLOT_WIDTH  = DefSlotWidth,
  parameter int unsigned SCK_DIV     = DefSckDiv,
  parameter int unsigned SKIP_FRAMES = DefSkipFrames,
  parameter int unsigned DC_SHIFT    = DefDcShift
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            i2s_sd,
  output logic            i2s_sck,
  output logic            i2s_ws,
  output logic            overrun,
  i2s_stereo_rx_if.master smp
);
  localparam int unsigned SckW  = $clog2(SCK_DIV);
  localparam int unsigned BitW  = $clog2(2 * SLOT_WIDTH);
  localparam int unsigned SkipW = $clog2(SKIP_FRAMES + 2);

  if (DATA_WIDTH < 2 || SLOT_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("i2s_stereo_rx: need 2 <= DATA_WIDTH <= SLOT_WIDTH");
  end
  if (SCK_DIV < 4 || (SCK_DIV % 2) != 0) begin : g_bad_div
    $error("i2s_stereo_rx: SCK_DIV must be even and >= 4");
  end
  if (DC_SHIFT == 0 || DATA_WIDTH + DC_SHIFT > 31) begin : g_bad_shift
    $error("i2s_stereo_rx: DC_SHIFT out of range");
  end

  i2s_state_e            state_q, state_d;
  logic [SckW-1:0]       sck_cnt_q, sck_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SkipW-1:0]      skip_cnt_q, skip_cnt_d;
  logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d;
  logic [DATA_WIDTH-1:0] right_sr_q, right_sr_d;
  logic                  sd_q;
  logic                  tick;
  logic                  frame_end;
  logic                  pair_done;
  logic                  deliver;

  always_comb begin
    state_d    = state_q;
    sck_cnt_d  = sck_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    skip_cnt_d = skip_cnt_q;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    tick       = 1'b0;
    frame_end  = 1'b0;
    pair_done  = 1'b0;
    if (!enable) begin
      state_d    = StIdle;
      sck_cnt_d  = '0;
      bit_cnt_d  = '0;
      skip_cnt_d = '0;
      left_sr_d  = '0;
      right_sr_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = (SKIP_FRAMES == 0) ? StRun : StSkip;
        StSkip, StRun: begin
          tick = (sck_cnt_q == SckW'(SCK_DIV - 1));
          if (tick) begin
            sck_cnt_d = '0;
            if (bit_cnt_q < BitW'(DATA_WIDTH)) begin
              left_sr_d = {left_sr_q[DATA_WIDTH-2:0], sd_q};
            end
            if (bit_cnt_q >= BitW'(SLOT_WIDTH) &&
                bit_cnt_q < BitW'(SLOT_WIDTH + DATA_WIDTH)) begin
              right_sr_d = {right_sr_q[DATA_WIDTH-2:0], sd_q};
            end
            pair_done = (bit_cnt_q == BitW'(SLOT_WIDTH + DATA_WIDTH - 1));
            if (bit_cnt_q == BitW'(2 * SLOT_WIDTH - 1)) begin
              bit_cnt_d = '0;
              frame_end = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            sck_cnt_d = sck_cnt_q + 1'b1;
          end
          if (state_q == StSkip && frame_end) begin
            if (skip_cnt_q == SkipW'(SKIP_FRAMES - 1)) begin
              state_d    = StRun;
              skip_cnt_d = '0;
            end else begin
              skip_cnt_d = skip_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sck_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      skip_cnt_q <= '0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
      sd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_cnt_q  <= sck_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      sd_q       <= i2s_sd;
    end
  end

  assign i2s_sck = (sck_cnt_q >= SckW'(SCK_DIV / 2));
  // ws leads each slot MSB by one bit period.
  assign i2s_ws  = (bit_cnt_q >= BitW'(SLOT_WIDTH - 1)) &&
                   (bit_cnt_q <= BitW'(2 * SLOT_WIDTH - 2));
  // Pairs completing while still settling are dropped without flagging overrun.
  assign deliver = pair_done && (state_q == StRun);

  logic                  new_valid;
  logic [DATA_WIDTH-1:0] new_left;
  logic [DATA_WIDTH-1:0] new_right;
  logic [DATA_WIDTH-1:0] left_out_q, right_out_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  load;

  assign load = new_valid && (!valid_q || smp.sample_ready);

`ifdef I2S_RX_DC_BLOCK_EN
  logic                         stg_valid_q;
  logic [DATA_WIDTH-1:0]        stg_left_q, stg_right_q;
  logic signed [DATA_WIDTH-1:0] left_y, right_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_left_q  <= '0;
      stg_right_q <= '0;
    end else begin
      stg_valid_q <= deliver;
      if (deliver) begin
        stg_left_q  <= left_sr_q;
        stg_right_q <= right_sr_d;
      end
    end
  end

  i2s_dc_block #(
    .DATA_WIDTH(DATA_WIDTH),
    .DC_SHIFT  (DC_SHIFT)
  ) u_dc_left (
    .clk   (clk),
    .reset (reset),
    .x     (stg_left_q),
    .update(load),
    .y     (left_y)
  );

  i2s_dc_block #(
    .DATA_WIDTH(DATA_WIDTH),
    .DC_SHIFT  (DC_SHIFT)
  ) u_dc_right (
    .clk   (clk),
    .reset (reset),
    .x     (stg_right_q),
    .update(load),
    .y     (right_y)
  );

  assign new_valid = stg_valid_q;
  assign new_left  = left_y;
  assign new_right = right_y;
`else
  assign new_valid = deliver;
  assign new_left  = left_sr_q;
  assign new_right = right_sr_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_out_q  <= '0;
      right_out_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (new_valid) begin
      if (load) begin
        left_out_q  <= new_left;
        right_out_q <= new_right;
        valid_q     <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (smp.sample_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign smp.left_data_out  = left_out_q;
  assign smp.right_data_out = right_out_q;
  assign smp.sample_valid   = valid_q;
  assign overrun            = overrun_q;

endmodule
